// File: rtl/if_sched_pkg.sv
// Shared definitions for the integrate-and-fire neuron scheduler.
// Contents:
//   sched_state_e   : sweep FSM states (IDLE, READ, UPDATE, DONE)
//   DEF_*           : default parameter values
//   idx_width()     : width of the neuron index register
//   refrac_width()  : width of a refractory down-counter
package if_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_READ   = 2'd1,
    S_UPDATE = 2'd2,
    S_DONE   = 2'd3
  } sched_state_e;

  localparam int DEF_N_NEURONS    = 4;
  localparam int DEF_WIDTH        = 8;
  localparam int DEF_THRESHOLD    = 200;
  localparam int DEF_REFRAC_TICKS = 2;

  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // A zero refractory period still needs a 1-bit counter to keep ports legal.
  function automatic int refrac_width(input int ticks);
    return (ticks <= 1) ? 1 : $clog2(ticks + 1);
  endfunction

endpackage

// File: rtl/if_update_unit.sv
// Combinational integrate-and-fire update for one neuron.
// Ports:
//   i_state       : committed membrane state
//   i_current     : input current for this sweep
//   i_refrac      : remaining refractory sweeps
//   o_next_state  : membrane state to write back
//   o_next_refrac : refractory count to write back
//   o_spike       : neuron fires this sweep
module if_update_unit
  import if_sched_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int THRESHOLD    = DEF_THRESHOLD,
  parameter int REFRAC_TICKS = DEF_REFRAC_TICKS,
  parameter int RW           = refrac_width(DEF_REFRAC_TICKS)
) (
  input  logic [WIDTH-1:0] i_state,
  input  logic [WIDTH-1:0] i_current,
  input  logic [RW-1:0]    i_refrac,
  output logic [WIDTH-1:0] o_next_state,
  output logic [RW-1:0]    o_next_refrac,
  output logic             o_spike
);

  localparam logic [WIDTH:0] THR    = (WIDTH+1)'(THRESHOLD);
  localparam logic [RW-1:0]  REFRAC = RW'(REFRAC_TICKS);

  // One extra bit so state + current never wraps before the compare.
  logic [WIDTH:0] w_sum;
  assign w_sum = {1'b0, i_state} + {1'b0, i_current};

  always_comb begin
    o_next_state  = w_sum[WIDTH-1:0];
    o_next_refrac = '0;
    o_spike       = 1'b0;
    if (i_refrac != '0) begin
      o_next_state  = '0;
      o_next_refrac = i_refrac - 1'b1;
    end else if (w_sum >= THR) begin
      o_next_state  = '0;
      o_next_refrac = REFRAC;
      o_spike       = 1'b1;
    end
  end

endmodule

// File: rtl/if_neuron_scheduler.sv
// Time-multiplexed integrate-and-fire scheduler: one update datapath swept
// across N_NEURONS virtual neurons held in a local register file.
// Ports:
//   clk, rst   : clock (rising edge), asynchronous active-high reset
//   tick       : single-cycle sweep request
//   current    : per-neuron currents, neuron i at current[i*WIDTH +: WIDTH]
//   sel        : neuron whose committed state drives state_out
//   busy       : sweep in progress (FSM not IDLE)
//   done       : one-cycle pulse when a sweep's spikes are published
//   spikes     : spike vector of the last completed sweep
//   state_out  : committed membrane state of neuron sel
//   overrun    : sticky, a tick arrived while busy and was dropped
//   dbg_state  : current FSM state
//
// Handshake: tick is a request without ready. It is accepted only when the
// FSM is IDLE; any tick seen in READ/UPDATE/DONE is discarded and sets
// overrun. The currents are captured on the accepting edge, so later changes
// on current do not affect the running sweep.
module if_neuron_scheduler
  import if_sched_pkg::*;
#(
  parameter int N_NEURONS    = DEF_N_NEURONS,
  parameter int WIDTH        = DEF_WIDTH,
  parameter int THRESHOLD    = DEF_THRESHOLD,
  parameter int REFRAC_TICKS = DEF_REFRAC_TICKS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         tick,
  input  logic [N_NEURONS*WIDTH-1:0]   current,
  input  logic [$clog2(N_NEURONS)-1:0] sel,
  output logic                         busy,
  output logic                         done,
  output logic [N_NEURONS-1:0]         spikes,
  output logic [WIDTH-1:0]             state_out,
  output logic                         overrun,
  output sched_state_e                 dbg_state
);

  localparam int IW = idx_width(N_NEURONS);
  localparam int RW = refrac_width(REFRAC_TICKS);

  sched_state_e         r_fsm;
  logic [IW-1:0]        r_idx;
  logic [WIDTH-1:0]     r_state_mem  [N_NEURONS];
  logic [RW-1:0]        r_refrac_mem [N_NEURONS];
  logic [WIDTH-1:0]     r_shadow     [N_NEURONS];
  logic [WIDTH-1:0]     r_cur_state;
  logic [RW-1:0]        r_cur_refrac;
  logic [WIDTH-1:0]     r_cur_current;
  logic [N_NEURONS-1:0] r_work;
  logic [N_NEURONS-1:0] r_spikes;
  logic                 r_done;
  logic                 r_overrun;

  logic [WIDTH-1:0]     w_next_state;
  logic [RW-1:0]        w_next_refrac;
  logic                 w_spike;

  if_update_unit #(
    .WIDTH        (WIDTH),
    .THRESHOLD    (THRESHOLD),
    .REFRAC_TICKS (REFRAC_TICKS),
    .RW           (RW)
  ) u_update (
    .i_state       (r_cur_state),
    .i_current     (r_cur_current),
    .i_refrac      (r_cur_refrac),
    .o_next_state  (w_next_state),
    .o_next_refrac (w_next_refrac),
    .o_spike       (w_spike)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fsm         <= S_IDLE;
      r_idx         <= '0;
      r_cur_state   <= '0;
      r_cur_refrac  <= '0;
      r_cur_current <= '0;
      r_work        <= '0;
      r_spikes      <= '0;
      r_done        <= 1'b0;
      r_overrun     <= 1'b0;
      for (int i = 0; i < N_NEURONS; i++) begin
        r_state_mem[i]  <= '0;
        r_refrac_mem[i] <= '0;
        r_shadow[i]     <= '0;
      end
    end else begin
      r_done <= 1'b0;
      if (tick && (r_fsm != S_IDLE)) r_overrun <= 1'b1;
      case (r_fsm)
        S_IDLE: begin
          if (tick) begin
            for (int i = 0; i < N_NEURONS; i++) begin
              r_shadow[i] <= current[i*WIDTH +: WIDTH];
            end
            r_idx  <= '0;
            r_work <= '0;
            r_fsm  <= S_READ;
          end
        end
        S_READ: begin
          r_cur_state   <= r_state_mem[r_idx];
          r_cur_refrac  <= r_refrac_mem[r_idx];
          r_cur_current <= r_shadow[r_idx];
          r_fsm         <= S_UPDATE;
        end
        S_UPDATE: begin
          r_state_mem[r_idx]  <= w_next_state;
          r_refrac_mem[r_idx] <= w_next_refrac;
          r_work[r_idx]       <= w_spike;
          if (r_idx == IW'(N_NEURONS - 1)) begin
            r_fsm <= S_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
            r_fsm <= S_READ;
          end
        end
        S_DONE: begin
          // Spikes and done are published together on the edge leaving DONE.
          r_spikes <= r_work;
          r_done   <= 1'b1;
          r_fsm    <= S_IDLE;
        end
        default: r_fsm <= S_IDLE;
      endcase
    end
  end

  assign busy      = (r_fsm != S_IDLE);
  assign done      = r_done;
  assign spikes    = r_spikes;
  assign overrun   = r_overrun;
  assign state_out = r_state_mem[sel];
  assign dbg_state = r_fsm;

endmodule

// File: tb/tb_if_neuron_scheduler.sv
module tb_if_neuron_scheduler;
  import if_sched_pkg::*;

  // clock / reset
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         tick = 1'b0;
  logic [31:0]  current = '0;
  logic [1:0]   sel = '0;
  logic         busy, done, overrun;
  logic [3:0]   spikes;
  logic [7:0]   state_out;
  sched_state_e dbg_state;

  always #5 clk = ~clk;

  if_neuron_scheduler #(
    .N_NEURONS(4), .WIDTH(8), .THRESHOLD(200), .REFRAC_TICKS(2)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .current(current), .sel(sel),
    .busy(busy), .done(done), .spikes(spikes), .state_out(state_out),
    .overrun(overrun), .dbg_state(dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Vector: optional reset first, currents {n3,n2,n1,n0}, expected states
  // after the sweep {n3,n2,n1,n0}, expected spike vector.
  typedef struct {
    bit          do_reset;
    logic [31:0] cur;
    logic [31:0] exp_states;
    logic [3:0]  exp_spikes;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    tick = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, {31'd0, done}, 32'd1);
  endtask

  task automatic check_states(input string name, input logic [31:0] exp);
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      #1;
      check($sformatf("%s_n%0d", name, i), {24'd0, state_out}, {24'd0, exp[i*8 +: 8]});
    end
  endtask

  task automatic run_sweep(input string name);
    @(negedge clk);
    tick = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0;
    wait_done({name, "_done"});
  endtask

  initial begin
    int done_cnt;
    bit seen_done;

    vecs[0] = '{1'b1, 32'h32323232, 32'h32323232, 4'b0000};
    vecs[1] = '{1'b0, 32'h32323232, 32'h64646464, 4'b0000};
    vecs[2] = '{1'b0, 32'h32323232, 32'h96969696, 4'b0000};
    vecs[3] = '{1'b0, 32'h32323232, 32'h00000000, 4'b1111};
    vecs[4] = '{1'b0, 32'h64646464, 32'h00000000, 4'b0000};
    vecs[5] = '{1'b0, 32'h64646464, 32'h00000000, 4'b0000};
    vecs[6] = '{1'b0, 32'h64646464, 32'h64646464, 4'b0000};
    vecs[7] = '{1'b1, 32'hC76400FF, 32'hC7640000, 4'b0001};
    vecs[8] = '{1'b0, 32'hC76400FF, 32'h00000000, 4'b1100};

    // Reset state
    do_reset();
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_spikes", {28'd0, spikes}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    check_states("rst_state", 32'h0);

    // Table-driven sweeps (plan items 1-3)
    for (int v = 0; v < 9; v++) begin
      if (vecs[v].do_reset) do_reset();
      current = vecs[v].cur;
      run_sweep($sformatf("v%0d", v));
      check($sformatf("v%0d_spikes", v), {28'd0, spikes}, {28'd0, vecs[v].exp_spikes});
      check_states($sformatf("v%0d_state", v), vecs[v].exp_states);
      repeat (2) @(negedge clk);
    end
    check("vec_overrun", {31'd0, overrun}, 32'd0);

    // Dropped tick at t+3: exactly one done after edge t+9, overrun sticky
    do_reset();
    current = 32'hFFFFFFFF;
    @(negedge clk);
    tick = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0;
    check("t4_busy_k0", {31'd0, busy}, 32'd1);
    done_cnt = 0;
    for (int k = 1; k <= 12; k++) begin
      tick = (k == 3);
      @(posedge clk);
      #1;
      if (done) done_cnt++;
      check($sformatf("t4_done_k%0d", k), {31'd0, done}, {31'd0, k == 9});
      check($sformatf("t4_busy_k%0d", k), {31'd0, busy}, {31'd0, k <= 8});
      check($sformatf("t4_ovr_k%0d", k), {31'd0, overrun}, {31'd0, k >= 3});
    end
    tick = 1'b0;
    check("t4_done_count", done_cnt, 1);
    check("t4_spikes", {28'd0, spikes}, 32'hF);

    // Reset in the middle of a sweep
    @(negedge clk);
    tick = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("t5_busy_pre", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_done", {31'd0, done}, 32'd0);
    check("t5_spikes", {28'd0, spikes}, 32'd0);
    check("t5_overrun", {31'd0, overrun}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check_states("t5_state", 32'h0);
    seen_done = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (done || busy) seen_done = 1'b1;
    end
    check("t5_no_done", {31'd0, seen_done}, 32'd0);

    // Current changes mid-sweep are ignored
    do_reset();
    current = 32'h0A0A0A0A;
    @(negedge clk);
    tick = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    current = 32'hFFFFFFFF;
    wait_done("t6_done");
    check("t6_spikes", {28'd0, spikes}, 32'd0);
    check_states("t6_state", 32'h0A0A0A0A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/if_neuron_scheduler.md
Name: if_neuron_scheduler

Overview:
- Time-multiplexes one integrate-and-fire update datapath across N_NEURONS virtual neurons.
- Each accepted `tick` runs one sweep. A sweep reads each neuron's membrane state from a local register file, adds that neuron's input current, applies the threshold and refractory rules, and writes the result back.
- Sits between the top-level pin wrapper and the neuron state. It replaces the one-neuron-per-pin arrangement so several neurons share the pins.

Parameters:
- N_NEURONS, 4: number of virtual neurons (power of 2, 2..16).
- WIDTH, 8: membrane-state and current width, in bits.
- THRESHOLD, 200: a neuron fires when state + current >= THRESHOLD. Must satisfy 1 <= THRESHOLD <= 2^WIDTH-1.
- REFRAC_TICKS, 2: number of sweeps a neuron ignores input after it fires (0 disables the refractory period).

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- tick, input, 1: single-cycle request to run one sweep.
- current, input, N_NEURONS*WIDTH: per-neuron input current; neuron i uses current[i*WIDTH +: WIDTH].
- sel, input, $clog2(N_NEURONS): selects which neuron's state appears on state_out.
- busy, output, 1: high in every state except IDLE.
- done, output, 1: one-cycle pulse at the end of a sweep.
- spikes, output, N_NEURONS: spike vector from the last completed sweep.
- state_out, output, WIDTH: committed membrane state of neuron `sel`.
- overrun, output, 1: sticky flag, set when a tick is dropped.

Behaviour:
- Reset values: every state register, refractory counter and the `spikes` register go to 0. FSM goes to IDLE; busy=0, done=0, overrun=0.
- FSM states: IDLE -> READ -> UPDATE -> (READ if idx < N_NEURONS-1, otherwise DONE) -> IDLE.
- IDLE: when tick=1, latch all of `current` into a shadow register, clear idx and the working spike vector, and go to READ.
- READ: fetch state[idx] and refrac[idx] into pipeline registers.
- UPDATE, first rule that applies wins:
  - refrac[idx] != 0: state[idx] stays 0, refrac[idx] decrements, no spike.
  - Otherwise compute sum = state + current on WIDTH+1 bits, with no wrap. If sum >= THRESHOLD: set working spike bit idx, state[idx] <= 0, refrac[idx] <= REFRAC_TICKS.
  - Otherwise state[idx] <= sum[WIDTH-1:0]. This is exact, because sum < THRESHOLD <= 2^WIDTH-1.
  - Then idx increments.
- DONE: `spikes` <= working vector and done=1 for this single cycle; next state is IDLE. `spikes` then holds its value until the next DONE.
- Latency: if tick is sampled at edge t, done is high in the cycle after edge t+2*N_NEURONS+1 (2 cycles per neuron plus 1 DONE cycle). Sweeps therefore start at most once every 2*N_NEURONS+2 cycles.
- Ticks outside IDLE (any busy state, including DONE): dropped, overrun <= 1. The sweep in progress is unaffected and no sweep is queued. overrun clears only on rst.
- Current changes mid-sweep have no effect; the sweep uses the currents latched on the accepted tick.
- state_out is combinational from the register file and shows committed values only. A neuron's value changes on the edge that ends its UPDATE cycle.
- Reset asserted mid-sweep: immediate return to reset values. No done pulse, partial results are discarded, and overrun clears.

Decomposition:
- Package if_sched_pkg holds:
  - the FSM state enum (IDLE, READ, UPDATE, DONE);
  - the default parameter values;
  - a function that computes the idx width.
- One combinational sub-module, if_update_unit, takes state, current and refrac and returns next_state, next_refrac and spike. The scheduler owns the FSM, the register file and the shadow current register.

Test Plan (N=4, WIDTH=8, THRESHOLD=200, REFRAC_TICKS=2):
1. All currents 50, four ticks spaced 12 cycles apart -> after each done, states read 50, 100, 150, then 0. spikes=4'b0000 after sweeps 1-3 and 4'b1111 after sweep 4.
2. Continue from test 1 with all currents 100, three more ticks -> sweeps 5 and 6 give states 0 and spikes 0 (refractory); sweep 7 gives states 100 and spikes 0.
3. Currents {n0=255, n1=0, n2=100, n3=199}, from reset, two ticks:
   - Sweep 1: spikes=4'b0001; states 0, 0, 100, 199.
   - Sweep 2 (n0 still refractory): spikes=4'b1100 (n2 sum 200, n3 sum 398 without overflow); n1 state 0.
4. tick at edge t, then a second tick at t+3 -> exactly one done, at the cycle after edge t+9, with width 1 cycle. overrun=1 and stays 1. busy is high from t+1 through the DONE cycle.
5. Tick, then assert rst for 1 cycle at t+4 -> busy, done, spikes and overrun all 0 immediately. state_out=0 for every sel and no done follows.
6. Tick with currents 10, then change `current` to 255 at t+2 -> states end at 10 with no spikes, confirming the latched currents were used.
